arm_regfile_mp: RTL and testbench

//  Parametrised multi-port ARM register file: NUM_REGS x DATA_W flip-flop array with NUM_RD read ports and two write ports.

---
 rtl/arm_regfile_mp.sv | 104 ++++++++++
 tb/tb_arm_regfile_mp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: two write ports, same-cycle write-to-read bypass,
// an auto-incrementing PC in the top register, and a pending-load scoreboard with stall.
module arm_regfile_mp #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          NUM_REGS = 16,
  parameter int unsigned          ADDR_W   = 4,
  parameter int unsigned          NUM_RD   = 3,
  parameter logic [DATA_W-1:0]    PC_RESET = '0,
  parameter int unsigned          PC_INC   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  input  logic [NUM_RD-1:0]          i_rd_use,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic                       i_wa_en,
  input  logic [ADDR_W-1:0]          i_wa_addr,
  input  logic [DATA_W-1:0]          i_wa_data,
  input  logic                       i_wb_en,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  input  logic                       i_pc_en,
  output logic [DATA_W-1:0]          o_pc_out,
  input  logic                       i_ld_issue,
  input  logic [ADDR_W-1:0]          i_ld_addr,
  output logic [NUM_RD-1:0]          o_rd_busy,
  output logic                       o_stall
);

  localparam logic [ADDR_W:0]   LP_NREGS    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LP_PC_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] LP_PC_STEP  = DATA_W'(PC_INC);
  localparam logic [DATA_W-1:0] LP_PC_AHEAD = DATA_W'(2 * PC_INC);

  logic [DATA_W-1:0]   r_gpr [NUM_REGS-1];
  logic [DATA_W-1:0]   r_pc;
  logic [NUM_REGS-1:0] r_pending;

  logic w_wa_pc;
  logic w_wb_pc;

  assign w_wa_pc = i_wa_en && (i_wa_addr == LP_PC_IDX);
  assign w_wb_pc = i_wb_en && (i_wb_addr == LP_PC_IDX);

  // Out-of-range write addresses never match a loop index, so they fall away naturally.
  // NOTE: the array is flop-based and must come out of reset cleared, so every entry
  // sits under the async reset; non-blocking assignments keep all updates in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS) - 1; i++) r_gpr[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS) - 1; i++) begin
        if (i_wa_en && (i_wa_addr == ADDR_W'(i)))      r_gpr[i] <= i_wa_data;
        else if (i_wb_en && (i_wb_addr == ADDR_W'(i))) r_gpr[i] <= i_wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pc <= PC_RESET;
    else if (w_wa_pc)  r_pc <= i_wa_data;
    else if (w_wb_pc)  r_pc <= i_wb_data;
    else if (i_pc_en)  r_pc <= r_pc + LP_PC_STEP;
  end

  // A new load to the register being retired keeps it pending (back-to-back loads).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (i_ld_issue && (i_ld_addr == ADDR_W'(i)))    r_pending[i] <= 1'b1;
        else if (i_wb_en && (i_wb_addr == ADDR_W'(i)))  r_pending[i] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_valid;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_data;

    assign w_addr  = i_rd_addr[p*ADDR_W +: ADDR_W];
    assign w_valid = {1'b0, w_addr} < LP_NREGS;
    assign w_hit_a = i_wa_en && (i_wa_addr == w_addr);
    assign w_hit_b = i_wb_en && (i_wb_addr == w_addr);

    // The PC reads two instructions ahead, but a bypassed write returns the raw value.
    assign w_data = !w_valid               ? '0 :
                    w_hit_a                ? i_wa_data :
                    w_hit_b                ? i_wb_data :
                    (w_addr == LP_PC_IDX)  ? r_pc + LP_PC_AHEAD :
                                             r_gpr[w_addr];

    assign o_rd_data[p*DATA_W +: DATA_W] = w_data;
    assign o_rd_busy[p] = w_valid && r_pending[w_addr] && !w_hit_b;
  end

  assign o_pc_out = r_pc;
  assign o_stall  = |(o_rd_busy & i_rd_use);

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Directed self-checking bench for arm_regfile_mp: reset, bypass, port collision,
// PC sequencing, and pending-load scoreboard behaviour.
module tb_arm_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [2:0]  rd_use;
  logic [95:0] rd_data;
  logic        wa_en;
  logic [3:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_en;
  logic [31:0] pc_out;
  logic        ld_issue;
  logic [3:0]  ld_addr;
  logic [2:0]  rd_busy;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  arm_regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_addr  (rd_addr),
    .i_rd_use   (rd_use),
    .o_rd_data  (rd_data),
    .i_wa_en    (wa_en),
    .i_wa_addr  (wa_addr),
    .i_wa_data  (wa_data),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_pc_en    (pc_en),
    .o_pc_out   (pc_out),
    .i_ld_issue (ld_issue),
    .i_ld_addr  (ld_addr),
    .o_rd_busy  (rd_busy),
    .o_stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  task automatic set_rd(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; pc_en = 1'b0; ld_issue = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; rd_use = '0;
    wa_addr = '0; wa_data = '0; wb_addr = '0; wb_data = '0; ld_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_pc", pc_out, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);

    // Preload R1, then assert reset mid-cycle while a port A write is in flight.
    wa_en = 1'b1; wa_addr = 4'd1; wa_data = 32'h0000_1234;
    tick();
    idle();
    set_rd(4'd0, 4'd0, 4'd1);
    #1 check("preload_r1", rd(0), 32'h0000_1234);
    wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'h0000_00AA;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_r1", rd(0), 32'h0);
    check("rst_mid_pc", pc_out, 32'h0);
    check("rst_mid_busy", {29'b0, rd_busy}, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    set_rd(4'd0, 4'd0, 4'd3);
    #1 check("rst_no_write_r3", rd(0), 32'h0);

    // Write then read, plus same-cycle bypass on both write ports.
    wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEAD_BEEF;
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h0000_0066;
    set_rd(4'd6, 4'd3, 4'd0);
    #1;
    check("bypass_a_r3", rd(1), 32'hDEAD_BEEF);
    check("bypass_b_r6", rd(2), 32'h0000_0066);
    tick();
    idle();
    set_rd(4'd6, 4'd0, 4'd3);
    #1;
    check("read_r3", rd(0), 32'hDEAD_BEEF);
    check("read_r6", rd(2), 32'h0000_0066);

    // Collision on R5 with a pending load outstanding.
    ld_issue = 1'b1; ld_addr = 4'd5;
    tick();
    idle();
    set_rd(4'd0, 4'd0, 4'd5); rd_use = 3'b001;
    #1;
    check("pend_r5_busy", {29'b0, rd_busy}, 32'h1);
    check("pend_r5_stall", {31'b0, stall}, 32'h1);
    wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h22;
    #1;
    check("coll_bypass", rd(0), 32'h11);
    check("coll_retire_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    #1;
    check("coll_r5", rd(0), 32'h11);
    check("coll_pend_clear", {29'b0, rd_busy}, 32'h0);
    rd_use = 3'b000;

    // PC sequencing from a fresh reset.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    pc_en = 1'b1;
    repeat (3) tick();
    pc_en = 1'b0;
    set_rd(4'd0, 4'd0, 4'd15);
    #1;
    check("pc_after3", pc_out, 32'h0000_000C);
    check("pc_read_ahead", rd(0), 32'h0000_0014);
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h100; pc_en = 1'b1;
    #1 check("pc_bypass_raw", rd(0), 32'h100);
    tick();
    idle();
    check("pc_wa_wins", pc_out, 32'h100);
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h200; pc_en = 1'b1;
    tick();
    idle();
    check("pc_wb_over_inc", pc_out, 32'h200);
    wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'hFFFF_FFFC;
    tick();
    idle();
    pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    #1;
    check("pc_wrap", pc_out, 32'h0);
    check("pc_wrap_read", rd(0), 32'h8);

    // Scoreboard stall and retirement on read port 2.
    ld_issue = 1'b1; ld_addr = 4'd7;
    tick();
    idle();
    set_rd(4'd7, 4'd0, 4'd0); rd_use = 3'b100;
    #1;
    check("ld_r7_stall", {31'b0, stall}, 32'h1);
    check("ld_r7_busy", {29'b0, rd_busy}, 32'h4);
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h55;
    #1;
    check("ret_r7_stall", {31'b0, stall}, 32'h0);
    check("ret_r7_data", rd(2), 32'h55);
    tick();
    idle();
    ld_issue = 1'b1; ld_addr = 4'd7;
    tick();
    idle();
    rd_use = 3'b000;
    #1;
    check("nouse_busy", {29'b0, rd_busy}, 32'h4);
    check("nouse_stall", {31'b0, stall}, 32'h0);

    // Back-to-back load: issue and retire R2 in the same cycle.
    ld_issue = 1'b1; ld_addr = 4'd2;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h0000_0022;
    tick();
    idle();
    set_rd(4'd0, 4'd0, 4'd2); rd_use = 3'b001;
    #1;
    check("b2b_stall", {31'b0, stall}, 32'h1);
    check("b2b_data", rd(0), 32'h0000_0022);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
